// File: rtl/irq_controller.sv
// Interrupt controller: synchronizes and edge-detects request lines, prioritizes them,
// drives a single cpu_irq with a vector, and exposes MASK/PENDING/STATUS/EOI registers.
module irq_controller #(
  parameter int          NUM_SRC   = 4,
  parameter logic [15:0] BASE_ADDR = 16'hFF10,
  parameter logic [15:0] VEC_BASE  = 16'h0010
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src_irq,
  output logic               cpu_irq,
  input  logic               cpu_ack,
  output logic [15:0]        irq_vector,
  input  logic               wenable,
  input  logic [15:0]        waddr,
  input  logic [15:0]        wdata,
  input  logic [15:0]        raddr,
  output logic [15:0]        rdata
);

  localparam logic [15:0] ADDR_MASK   = BASE_ADDR;
  localparam logic [15:0] ADDR_PEND   = BASE_ADDR + 16'd1;
  localparam logic [15:0] ADDR_STATUS = BASE_ADDR + 16'd2;
  localparam logic [15:0] ADDR_EOI    = BASE_ADDR + 16'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t             state;
  logic [2:0]         active_id;
  logic [NUM_SRC-1:0] s1, s2, prev;
  logic [NUM_SRC-1:0] mask, pending;
  logic [NUM_SRC-1:0] rise, req, act_oh, pend_clr, wbits;
  logic               wr_mask, wr_pend, wr_eoi, ack_take, cancel;
  logic [2:0]         win_id;
  logic               win_found;

  assign wr_mask  = wenable && (waddr == ADDR_MASK);
  assign wr_pend  = wenable && (waddr == ADDR_PEND);
  assign wr_eoi   = wenable && (waddr == ADDR_EOI);
  assign wbits    = wdata[NUM_SRC-1:0];
  assign rise     = s2 & ~prev;
  assign req      = pending & mask;
  assign act_oh   = NUM_SRC'(1) << active_id;
  assign ack_take = (state == ASSERT) && cpu_ack;
  assign cancel   = (wr_mask && ((wbits & act_oh) == '0)) ||
                    (wr_pend && ((wbits & act_oh) != '0));
  assign pend_clr = (wr_pend ? wbits : '0) | (ack_take ? act_oh : '0);

  always_comb begin
    win_id    = '0;
    win_found = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (req[i] && !win_found) begin
        win_id    = 3'(i);
        win_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1      <= '0;
      s2      <= '0;
      prev    <= '0;
      mask    <= '0;
      pending <= '0;
    end else begin
      s1   <= src_irq;
      s2   <= s1;
      prev <= s2;
      if (wr_mask)
        mask <= wbits;
      // new edges are OR'd in after the clear so a coincident set wins
      pending <= (pending & ~pend_clr) | rise;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      active_id  <= '0;
      cpu_irq    <= 1'b0;
      irq_vector <= VEC_BASE;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            active_id  <= win_id;
            irq_vector <= VEC_BASE + {13'd0, win_id};
            cpu_irq    <= 1'b1;
            state      <= ASSERT;
          end
        end
        ASSERT: begin
          if (cpu_ack) begin
            cpu_irq <= 1'b0;
            state   <= SERVICE;
          end else if (cancel) begin
            cpu_irq   <= 1'b0;
            active_id <= '0;
            state     <= IDLE;
          end
        end
        SERVICE: begin
          cpu_irq <= 1'b0;
          if (wr_eoi) begin
            active_id <= '0;
            state     <= IDLE;
          end
        end
        default: begin
          cpu_irq   <= 1'b0;
          active_id <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    if (raddr == ADDR_MASK)
      rdata = 16'(mask);
    else if (raddr == ADDR_PEND)
      rdata = 16'(pending);
    else if (raddr == ADDR_STATUS)
      rdata = {9'd0, active_id, 2'd0, state};
  end

endmodule

// File: tb/tb_irq_controller.sv
// Scenario bench for irq_controller: expectations are queued as stimulus is applied
// and popped when the corresponding DUT output is sampled.
module tb_irq_controller;

  localparam logic [15:0] A_MASK   = 16'hFF10;
  localparam logic [15:0] A_PEND   = 16'hFF11;
  localparam logic [15:0] A_STATUS = 16'hFF12;
  localparam logic [15:0] A_EOI    = 16'hFF13;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  src_irq;
  logic        cpu_irq;
  logic        cpu_ack;
  logic [15:0] irq_vector;
  logic        wenable;
  logic [15:0] waddr, wdata, raddr, rdata;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] obs, exp_v;

  irq_controller #(.NUM_SRC(4), .BASE_ADDR(16'hFF10), .VEC_BASE(16'h0010)) dut (
    .clock(clock), .reset(reset), .src_irq(src_irq), .cpu_irq(cpu_irq),
    .cpu_ack(cpu_ack), .irq_vector(irq_vector), .wenable(wenable),
    .waddr(waddr), .wdata(wdata), .raddr(raddr), .rdata(rdata)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    wenable = 1'b1; waddr = a; wdata = d;
    tick();
    wenable = 1'b0; waddr = 16'h0000; wdata = 16'h0000;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
    raddr = a;
    #1;
    d = rdata;
  endtask

  task automatic ack_pulse();
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; src_irq = '0; cpu_ack = 1'b0; wenable = 1'b0;
    waddr = '0; wdata = '0; raddr = '0;
    tick(2);
    reset = 1'b0;
    tick();
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0010);
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0000);
    obs = {15'd0, cpu_irq}; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset_cpu_irq: got %h want %h", obs, exp_v); end
    obs = irq_vector; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset_vector: got %h want %h", obs, exp_v); end
    bus_read(A_MASK, obs); exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset_mask: got %h want %h", obs, exp_v); end
    bus_read(A_PEND, obs); exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset_pending: got %h want %h", obs, exp_v); end
    bus_read(A_STATUS, obs); exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset_status: got %h want %h", obs, exp_v); end
    bus_write(16'h1234, 16'hFFFF);
    bus_read(16'h1234, obs); exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL unmapped_read: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_masked_pending();
    src_irq[1] = 1'b1;
    tick(5);
    src_irq[1] = 1'b0;
    tick(2);
    exp_q.push_back(16'h0002); exp_q.push_back(16'h0000);
    bus_read(A_PEND, obs); exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL masked_pending: got %h want %h", obs, exp_v); end
    obs = {15'd0, cpu_irq}; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL masked_no_irq: got %h want %h", obs, exp_v); end
    bus_write(A_MASK, 16'h0002);
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0001); exp_q.push_back(16'h0011);
    obs = {15'd0, cpu_irq}; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL unmask_same_cycle: got %h want %h", obs, exp_v); end
    tick();
    obs = {15'd0, cpu_irq}; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL unmask_irq: got %h want %h", obs, exp_v); end
    obs = irq_vector; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL unmask_vector: got %h want %h", obs, exp_v); end
    ack_pulse();
    bus_write(A_EOI, 16'h0000);
    tick();
  endtask

  task automatic test_priority();
    bus_write(A_MASK, 16'h000F);
    src_irq[2] = 1'b1; src_irq[0] = 1'b1;
    exp_q.push_back(16'h0005); exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0001); exp_q.push_back(16'h0010);
    tick(3);
    bus_read(A_PEND, obs); exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL sync_latency_pending: got %h want %h", obs, exp_v); end
    obs = {15'd0, cpu_irq}; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL sync_latency_irq_early: got %h want %h", obs, exp_v); end
    tick();
    obs = {15'd0, cpu_irq}; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL prio_irq: got %h want %h", obs, exp_v); end
    obs = irq_vector; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL prio_vector: got %h want %h", obs, exp_v); end
    src_irq[2] = 1'b0; src_irq[0] = 1'b0;
    ack_pulse();
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0002); exp_q.push_back(16'h0004);
    obs = {15'd0, cpu_irq}; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL ack_irq_low: got %h want %h", obs, exp_v); end
    bus_read(A_STATUS, obs); exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL ack_status: got %h want %h", obs, exp_v); end
    bus_read(A_PEND, obs); exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL ack_pending: got %h want %h", obs, exp_v); end
    bus_write(A_EOI, 16'hABCD);
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0012); exp_q.push_back(16'h0021);
    obs = {15'd0, cpu_irq}; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL eoi_irq_early: got %h want %h", obs, exp_v); end
    tick();
    obs = {15'd0, cpu_irq}; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL eoi_next_irq: got %h want %h", obs, exp_v); end
    obs = irq_vector; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL eoi_next_vector: got %h want %h", obs, exp_v); end
    bus_read(A_STATUS, obs); exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL eoi_next_status: got %h want %h", obs, exp_v); end
    ack_pulse();
    bus_write(A_EOI, 16'h0000);
    tick();
  endtask

  task automatic test_mask_cancel();
    src_irq[3] = 1'b1;
    tick(4);
    src_irq[3] = 1'b0;
    exp_q.push_back(16'h0013);
    obs = irq_vector; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL src3_vector: got %h want %h", obs, exp_v); end
    bus_write(A_MASK, 16'h0000);
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0000); exp_q.push_back(16'h0008);
    obs = {15'd0, cpu_irq}; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL cancel_irq: got %h want %h", obs, exp_v); end
    bus_read(A_STATUS, obs); exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL cancel_status: got %h want %h", obs, exp_v); end
    bus_read(A_PEND, obs); exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL cancel_pending: got %h want %h", obs, exp_v); end
    bus_write(A_PEND, 16'h0008);
    exp_q.push_back(16'h0000);
    bus_read(A_PEND, obs); exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL w1c_pending: got %h want %h", obs, exp_v); end
    bus_write(A_MASK, 16'h000F);
    tick(2);
  endtask

  task automatic test_back_to_back();
    src_irq[0] = 1'b1;
    tick(4);
    src_irq[0] = 1'b0;
    exp_q.push_back(16'h0001);
    obs = {15'd0, cpu_irq}; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL src0_irq: got %h want %h", obs, exp_v); end
    tick(4);
    // rise lands on the third edge, coincident with the acknowledge
    src_irq[0] = 1'b1;
    tick(2);
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
    src_irq[0] = 1'b0;
    exp_q.push_back(16'h0001); exp_q.push_back(16'h0002); exp_q.push_back(16'h0000);
    bus_read(A_PEND, obs); exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL set_wins_pending: got %h want %h", obs, exp_v); end
    bus_read(A_STATUS, obs); exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL set_wins_status: got %h want %h", obs, exp_v); end
    obs = {15'd0, cpu_irq}; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL set_wins_irq: got %h want %h", obs, exp_v); end
    bus_write(A_EOI, 16'h0000);
    tick();
    exp_q.push_back(16'h0001); exp_q.push_back(16'h0010);
    obs = {15'd0, cpu_irq}; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reassert_irq: got %h want %h", obs, exp_v); end
    obs = irq_vector; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reassert_vector: got %h want %h", obs, exp_v); end
    ack_pulse();
    bus_write(A_EOI, 16'h0000);
    tick();
  endtask

  task automatic test_level_hold();
    int seen;
    int highs;
    seen = 0;
    highs = 0;
    src_irq[1] = 1'b1;
    exp_q.push_back(16'h0001); exp_q.push_back(16'h0000); exp_q.push_back(16'h0000);
    for (int i = 0; i < 10 && seen == 0; i++) begin
      tick();
      if (cpu_irq) seen = 1;
    end
    obs = 16'(seen); exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL level_first_request: got %h want %h", obs, exp_v); end
    ack_pulse();
    bus_write(A_EOI, 16'h0000);
    for (int i = 0; i < 90; i++) begin
      tick();
      if (cpu_irq) highs++;
    end
    obs = 16'(highs); exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL level_no_second: got %h want %h", obs, exp_v); end
    bus_read(A_PEND, obs); exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL level_pending: got %h want %h", obs, exp_v); end
    src_irq[1] = 1'b0;
    tick(4);
  endtask

  task automatic test_reset_in_service();
    src_irq[2] = 1'b1;
    tick(4);
    src_irq[2] = 1'b0;
    ack_pulse();
    exp_q.push_back(16'h0022);
    bus_read(A_STATUS, obs); exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL service_status: got %h want %h", obs, exp_v); end
    #2;
    reset = 1'b1;
    #1;
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0000); exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0010);
    obs = {15'd0, cpu_irq}; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL async_reset_irq: got %h want %h", obs, exp_v); end
    bus_read(A_MASK, obs); exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL async_reset_mask: got %h want %h", obs, exp_v); end
    bus_read(A_PEND, obs); exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL async_reset_pending: got %h want %h", obs, exp_v); end
    bus_read(A_STATUS, obs); exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL async_reset_status: got %h want %h", obs, exp_v); end
    obs = irq_vector; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL async_reset_vector: got %h want %h", obs, exp_v); end
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_masked_pending();
    test_priority();
    test_mask_cancel();
    test_back_to_back();
    test_level_hold();
    test_reset_in_service();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Collects interrupt requests from multiple IO drivers (PS/2 keyboard, VGA, timers) into the single irq line consumed by controlpath.
- Prioritizes the requests and presents a 16-bit vector for the selected source.
- Completes the acknowledge handshake with controlpath's reset_irq.
- Exposes memory-mapped mask, pending, status and end-of-interrupt (EOI) registers on the io_interface-style bus.

Parameters:
- NUM_SRC, 4, number of interrupt sources (1..8).
- BASE_ADDR, 16'hFF10, bus address of register 0. Registers occupy BASE_ADDR..BASE_ADDR+3.
- VEC_BASE, 16'h0010, vector for source 0. Source i gets VEC_BASE+i.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- src_irq  in  NUM_SRC  raw request lines, possibly from other clock domains. A rising edge triggers a request.
- cpu_irq  out  1  interrupt request to controlpath (its irq input).
- cpu_ack  in  1  acknowledge from controlpath (its reset_irq); single-cycle high pulse.
- irq_vector  out  16  vector of the asserted or in-service source.
- wenable  in  1  bus write strobe.
- waddr  in  16  bus write address.
- wdata  in  16  bus write data.
- raddr  in  16  bus read address.
- rdata  out  16  bus read data; combinational from raddr.

Behaviour:
- Reset (async, high):
  - mask=0, pending=0, sync/edge flops=0, state=IDLE, active_id=0.
  - cpu_irq=0, irq_vector=VEC_BASE.
  - Deasserting reset mid-service returns to IDLE with nothing pending.
- Input path: per source, a 2-flop synchronizer (s1, s2) plus a prev flop.
  - A rise is detected when s2 & ~prev; that edge sets pending[i].
  - pending[i] is visible 3 rising edges after the first edge that samples src_irq[i] high.
  - A level held high generates exactly one request until it falls and rises again.
- Registers (offsets from BASE_ADDR):
  - +0 MASK: rw; bits [NUM_SRC-1:0]; 1 = enabled; upper bits read 0.
  - +1 PENDING: read = pending; write-1-to-clear.
  - +2 STATUS: read only. [1:0] = state (IDLE=0, ASSERT=1, SERVICE=2); [6:4] = active_id; others 0.
  - +3 EOI: write of any data ends service. Reads 0.
  - Any other raddr: rdata = 0. Writes to other addresses are ignored.
- Priority: lowest index wins among (pending & mask).
- FSM:
  - IDLE:
    - If (pending & mask) != 0, latch winner into active_id, drive irq_vector = VEC_BASE+winner, cpu_irq=1, go to ASSERT.
    - cpu_irq rises the cycle after pending becomes visible.
  - ASSERT:
    - cpu_ack=1: clear pending[active_id], cpu_irq=0, go to SERVICE. irq_vector holds.
    - Otherwise, if mask[active_id] is written to 0 or pending[active_id] is W1C-cleared: cpu_irq=0, go to IDLE.
    - Otherwise hold. A higher-priority arrival does not preempt while in ASSERT.
  - SERVICE:
    - cpu_irq=0; further requests accumulate in pending.
    - EOI write goes to IDLE; the next winner can assert on the following cycle.
  - cpu_ack in IDLE or SERVICE is ignored.
- Simultaneous events:
  - Edge set and clear of the same pending bit in one cycle (ack clear or W1C): set wins.
  - MASK write and winner selection in the same cycle: selection uses the pre-write mask.
  - EOI and cpu_ack in the same cycle while in SERVICE: EOI taken, ack ignored.
- Pending bits are sticky regardless of mask. Unmasking a pending source triggers a request from IDLE.
- No combinational path from src_irq to cpu_irq; cpu_irq and irq_vector are registered.

Test Plan:
- Reset, then pulse src_irq[1] high for 5 cycles with MASK=0 -> PENDING reads 16'h0002, cpu_irq stays 0. Then write MASK=16'h0002 -> cpu_irq=1 next cycle, irq_vector=16'h0011.
- MASK=16'h000F, raise src_irq[2] and src_irq[0] on the same edge -> cpu_irq rises, vector 16'h0010. Pulse cpu_ack -> cpu_irq=0, STATUS=16'h0002, PENDING=16'h0004. Write EOI -> cpu_irq=1 one cycle later, vector 16'h0012.
- In ASSERT for source 3, write MASK=0 -> cpu_irq=0 next cycle, STATUS=16'h0000, PENDING bit 3 still 1.
- Rising edge of src_irq[0] detected in the same cycle cpu_ack clears pending[0] -> PENDING[0]=1 after ack, and source 0 re-asserts after EOI.
- Hold src_irq[1] high for 100 cycles -> exactly one request. cpu_ack plus EOI -> no second assertion.
- Assert reset while in SERVICE -> immediately cpu_irq=0, MASK=0, PENDING=0, STATUS=0, rdata at BASE_ADDR = 16'h0000.
